rs_station: RTL

Reservation station for the out-of-order RISC-V core. Sits between the issue stage and the ALU: accepts dispatch packets from issue, holds each instruction until both operands are valid, and captures missing operands by snooping the two result broadcast buses. Fires one ready instruction per cycle to the ALU, tagged with its ROB entry number.

---
 rtl/rs_station_pkg.sv | 25 ++
 rtl/rs_pick.sv | 23 ++
 rtl/rs_station.sv | 135 +++++++++++++
 3 files changed

// File: rtl/rs_station_pkg.sv
// rtl/rs_station_pkg.sv - shared core definitions used by the reservation station
package rs_station_pkg;

   localparam int OpSize      = 6;
   localparam int RegAddrSize = 5;

   // operand status value meaning "value already present"
   localparam logic [31:0] MAXN = 32'hffff_ffff;

   localparam logic [5:0] OP_ADD = 6'd1;
   localparam logic [5:0] OP_SUB = 6'd2;
   localparam logic [5:0] OP_AND = 6'd3;

   // returns {q, v} after snooping both result buses; the ALU bus overrides the LSB bus
   function automatic logic [63:0] snoop(input logic [31:0] q, input logic [31:0] v,
                                         input logic a_en, input logic [31:0] a_tag,
                                         input logic [31:0] a_val,
                                         input logic b_en, input logic [31:0] b_tag,
                                         input logic [31:0] b_val);
      snoop = {q, v};
      if (b_en && q == b_tag) snoop = {MAXN, b_val};
      if (a_en && q == a_tag) snoop = {MAXN, a_val};
   endfunction

endpackage

// File: rtl/rs_pick.sv
// rtl/rs_pick.sv - lowest-index priority encoder with valid flag
module rs_pick #(
   parameter int N  = 16,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   output logic          vld,
   output logic [IW-1:0] idx
);

   // scan from the top so the lowest set bit is the last one written
   always_comb begin
      vld = 1'b0;
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            vld = 1'b1;
            idx = IW'(i);
         end
      end
   end

endmodule

// File: rtl/rs_station.sv
// rtl/rs_station.sv - reservation station feeding the ALU (option: RS_ISSUE_BYPASS_EN)
module rs_station
   import rs_station_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int OP_W  = OpSize,
   parameter int TAG_W = RegAddrSize
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             rdy_in,
   input  logic             clear,
   input  logic             en_in,
   input  logic [OP_W-1:0]  OpCode,
   input  logic [TAG_W-1:0] ROB_Number,
   input  logic [31:0]      Reg_Status_1,
   input  logic [31:0]      Reg_Status_2,
   input  logic [31:0]      Reg_Data_1,
   input  logic [31:0]      Reg_Data_2,
   output logic             full_o,
   input  logic             cdb_alu_en,
   input  logic [TAG_W-1:0] cdb_alu_tag,
   input  logic [31:0]      cdb_alu_val,
   input  logic             cdb_lsb_en,
   input  logic [TAG_W-1:0] cdb_lsb_tag,
   input  logic [31:0]      cdb_lsb_val,
   output logic             alu_en_o,
   output logic [OP_W-1:0]  alu_op_o,
   output logic [31:0]      alu_a_o,
   output logic [31:0]      alu_b_o,
   output logic [TAG_W-1:0] alu_tag_o
);

   localparam int IW = $clog2(DEPTH);

   logic [DEPTH-1:0] busy;
   logic [DEPTH-1:0] rdy_vec;
   logic [OP_W-1:0]  op_q  [DEPTH];
   logic [31:0]      q1_q  [DEPTH];
   logic [31:0]      v1_q  [DEPTH];
   logic [31:0]      q2_q  [DEPTH];
   logic [31:0]      v2_q  [DEPTH];
   logic [TAG_W-1:0] tag_q [DEPTH];

   logic          free_vld, sel_vld;
   logic [IW-1:0] free_idx, sel_idx;
   logic [31:0]   in_q1, in_v1, in_q2, in_v2;
   logic [31:0]   alu_tag32, lsb_tag32;
   logic          accept, bypass, ins;

   assign alu_tag32 = 32'(cdb_alu_tag);
   assign lsb_tag32 = 32'(cdb_lsb_tag);
   assign full_o    = &busy;

   // an entry is selectable only once both operands are present
   always_comb begin
      rdy_vec = '0;
      for (int i = 0; i < DEPTH; i++)
         rdy_vec[i] = busy[i] && (q1_q[i] == MAXN) && (q2_q[i] == MAXN);
   end

   rs_pick #(.N(DEPTH), .IW(IW)) u_free_pick (.req(~busy),   .vld(free_vld), .idx(free_idx));
   rs_pick #(.N(DEPTH), .IW(IW)) u_sel_pick  (.req(rdy_vec), .vld(sel_vld),  .idx(sel_idx));

   // incoming operands may be satisfied by a broadcast in the same cycle
   always_comb begin
      {in_q1, in_v1} = snoop(Reg_Status_1, Reg_Data_1, cdb_alu_en, alu_tag32, cdb_alu_val,
                             cdb_lsb_en, lsb_tag32, cdb_lsb_val);
      {in_q2, in_v2} = snoop(Reg_Status_2, Reg_Data_2, cdb_alu_en, alu_tag32, cdb_alu_val,
                             cdb_lsb_en, lsb_tag32, cdb_lsb_val);
   end

   assign accept = en_in && free_vld;
`ifdef RS_ISSUE_BYPASS_EN
   assign bypass = accept && !sel_vld && (in_q1 == MAXN) && (in_q2 == MAXN);
`else
   assign bypass = 1'b0;
`endif
   assign ins = accept && !bypass;

   // busy bits and ALU output register: flush beats dispatch and insert
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         busy      <= '0;
         alu_en_o  <= 1'b0;
         alu_op_o  <= '0;
         alu_a_o   <= '0;
         alu_b_o   <= '0;
         alu_tag_o <= '0;
      end else if (rdy_in) begin
         if (clear) begin
            busy     <= '0;
            alu_en_o <= 1'b0;
         end else begin
            alu_en_o <= sel_vld || bypass;
            if (sel_vld) begin
               busy[sel_idx] <= 1'b0;
               alu_op_o      <= op_q[sel_idx];
               alu_a_o       <= v1_q[sel_idx];
               alu_b_o       <= v2_q[sel_idx];
               alu_tag_o     <= tag_q[sel_idx];
            end else if (bypass) begin
               alu_op_o  <= OpCode;
               alu_a_o   <= in_v1;
               alu_b_o   <= in_v2;
               alu_tag_o <= ROB_Number;
            end
            if (ins) busy[free_idx] <= 1'b1;
         end
      end
   end

   // entry payload: wakeup of waiting operands, then write of a newly inserted packet
   always_ff @(posedge clk_in) begin
      if (rdy_in) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (busy[i]) begin
               {q1_q[i], v1_q[i]} <= snoop(q1_q[i], v1_q[i], cdb_alu_en, alu_tag32, cdb_alu_val,
                                           cdb_lsb_en, lsb_tag32, cdb_lsb_val);
               {q2_q[i], v2_q[i]} <= snoop(q2_q[i], v2_q[i], cdb_alu_en, alu_tag32, cdb_alu_val,
                                           cdb_lsb_en, lsb_tag32, cdb_lsb_val);
            end
         end
         if (ins) begin
            op_q[free_idx]  <= OpCode;
            q1_q[free_idx]  <= in_q1;
            v1_q[free_idx]  <= in_v1;
            q2_q[free_idx]  <= in_q2;
            v2_q[free_idx]  <= in_v2;
            tag_q[free_idx] <= ROB_Number;
         end
      end
   end

endmodule
